// File: rtl/orv64_cache_noc_slv_demux_pkg.sv
// Shared types and defaults for the ORV64 cache-side NOC demux: request/response
// payloads broadcast to targets, and the target index type.
package orv64_cache_noc_slv_demux_pkg;

  localparam int ORV64_CNOC_N_TGT           = 2;
  localparam int ORV64_CNOC_MAX_OUTSTANDING = 4;

  localparam int ORV64_PADDR_W = 40;
  localparam int ORV64_TID_W   = 8;
  localparam int ORV64_DATA_W  = 64;

  typedef struct packed {
    logic [ORV64_PADDR_W-1:0] req_paddr;
    logic [ORV64_TID_W-1:0]   req_tid;
    logic [3:0]               req_type;
    logic [ORV64_DATA_W/8-1:0] req_mask;
    logic [ORV64_DATA_W-1:0]  req_data;
  } cpu_cache_if_req_t;

  typedef struct packed {
    logic [ORV64_TID_W-1:0]  resp_tid;
    logic [1:0]              resp_type;
    logic [ORV64_DATA_W-1:0] resp_data;
  } cpu_cache_if_resp_t;

  typedef logic [$clog2(ORV64_CNOC_N_TGT)-1:0] orv64_cnoc_tgt_idx_t;

endpackage

// File: rtl/orv64_cache_noc_resp_skid.sv
// One-entry response register between a target and the merge arbiter; accepts a
// new entry in the same cycle the held one drains, so throughput stays at 1/cycle.
module orv64_cache_noc_resp_skid
  import orv64_cache_noc_slv_demux_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  cpu_cache_if_resp_t in_data,
  output logic               in_ready,
  output logic               out_valid,
  output cpu_cache_if_resp_t out_data,
  input  logic               out_ready
);

  logic               vld;
  cpu_cache_if_resp_t data;

  assign in_ready  = ~vld | out_ready;
  assign out_valid = vld;
  assign out_data  = data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         vld <= 1'b0;
    else if (in_ready) vld <= in_valid;
  end

  // NOTE: the payload register has no reset; it is only observed while vld is set.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) data <= in_data;
  end

endmodule

// File: rtl/orv64_cache_noc_slv_demux.sv
// Steers CPU-NOC requests to N_TGT targets by paddr decode, bounds outstanding
// requests per target, and round-robin merges responses. Define
// ORV64_CACHE_NOC_ORDER_EN to also block requests while another target is busy.
module orv64_cache_noc_slv_demux
  import orv64_cache_noc_slv_demux_pkg::*;
#(
  parameter int N_TGT           = ORV64_CNOC_N_TGT,
  parameter int TGT_SEL_LSB     = 6,
  parameter int MAX_OUTSTANDING = ORV64_CNOC_MAX_OUTSTANDING
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cache_if_req_valid,
  input  cpu_cache_if_req_t              cache_if_req,
  output logic                           cache_if_req_ready,
  output logic                           cache_if_resp_valid,
  output cpu_cache_if_resp_t             cache_if_resp,
  input  logic                           cache_if_resp_ready,
  output logic [N_TGT-1:0]               tgt_req_valid,
  output cpu_cache_if_req_t [N_TGT-1:0]  tgt_req,
  input  logic [N_TGT-1:0]               tgt_req_ready,
  input  logic [N_TGT-1:0]               tgt_resp_valid,
  input  cpu_cache_if_resp_t [N_TGT-1:0] tgt_resp,
  output logic [N_TGT-1:0]               tgt_resp_ready
);

  localparam int IDX_W = $clog2(N_TGT);
  localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;

  idx_t               sel;
  logic               block;
  logic               other_busy;
  logic [N_TGT-1:0]   oc_nz;
  logic [N_TGT-1:0]   req_hs;
  logic [N_TGT-1:0]   resp_hs;
  logic [OC_W-1:0]    oc [N_TGT];

  logic [N_TGT-1:0]   skid_vld;
  logic [N_TGT-1:0]   skid_pop;
  cpu_cache_if_resp_t skid_data [N_TGT];

  idx_t rr_ptr, rr_pick, cand, grant, grant_q;
  logic grant_lock;

  // ---------------- request decode ----------------
  assign sel = cache_if_req.req_paddr[TGT_SEL_LSB +: IDX_W];

`ifdef ORV64_CACHE_NOC_ORDER_EN
  logic [N_TGT-1:0] sel_onehot;
  assign sel_onehot = N_TGT'(1) << sel;
  assign other_busy = |(oc_nz & ~sel_onehot);
`else
  assign other_busy = 1'b0;
`endif

  assign block              = (oc[sel] == OC_W'(MAX_OUTSTANDING)) | other_busy;
  assign cache_if_req_ready = tgt_req_ready[sel] & ~block;

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    tgt_req_valid      = '0;
    tgt_req_valid[sel] = cache_if_req_valid & ~block;
    for (int t = 0; t < N_TGT; t++) begin
      tgt_req[t] = cache_if_req;
      oc_nz[t]   = (oc[t] != '0);
    end
  end

  assign req_hs  = tgt_req_valid & tgt_req_ready;
  assign resp_hs = tgt_resp_valid & tgt_resp_ready;

  // Increment cannot overflow because block stops requests at the limit;
  // a stray response at zero is absorbed rather than wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < N_TGT; t++) oc[t] <= '0;
    end else begin
      for (int t = 0; t < N_TGT; t++) begin
        if (req_hs[t] && !resp_hs[t])                  oc[t] <= oc[t] + 1'b1;
        else if (!req_hs[t] && resp_hs[t] && oc_nz[t]) oc[t] <= oc[t] - 1'b1;
      end
    end
  end

  // ---------------- response skids ----------------
  for (genvar t = 0; t < N_TGT; t++) begin : g_skid
    assign skid_pop[t] = (grant == idx_t'(t)) & cache_if_resp_ready;

    orv64_cache_noc_resp_skid u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (tgt_resp_valid[t]),
      .in_data   (tgt_resp[t]),
      .in_ready  (tgt_resp_ready[t]),
      .out_valid (skid_vld[t]),
      .out_data  (skid_data[t]),
      .out_ready (skid_pop[t])
    );
  end

  // ---------------- round-robin merge ----------------
  // Scan from the highest offset down so the entry closest to rr_ptr wins.
  always_comb begin
    rr_pick = rr_ptr;
    cand    = rr_ptr;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      cand = rr_ptr + IDX_W'(i);
      if (skid_vld[cand]) rr_pick = cand;
    end
  end

  // A stalled grant is frozen so a later-arriving skid cannot swap the payload.
  assign grant               = grant_lock ? grant_q : rr_pick;
  assign cache_if_resp_valid = skid_vld[grant];
  assign cache_if_resp       = skid_data[grant];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr     <= '0;
      grant_q    <= '0;
      grant_lock <= 1'b0;
    end else begin
      grant_q    <= grant;
      grant_lock <= cache_if_resp_valid & ~cache_if_resp_ready;
      if (cache_if_resp_valid && cache_if_resp_ready) rr_ptr <= grant + 1'b1;
    end
  end

`ifndef SYNTHESIS
  resp_without_req : assert property (@(posedge clk) disable iff (!rstn)
    (resp_hs & ~oc_nz) == '0)
    else $error("orv64_cache_noc_slv_demux: response from target with no outstanding request");
`endif

endmodule

// File: tb/tb_orv64_cache_noc_slv_demux.sv
// Directed bench for orv64_cache_noc_slv_demux: stimulus pushes expected response
// tids into a scoreboard queue that an independent monitor drains.
module tb_orv64_cache_noc_slv_demux;
  import orv64_cache_noc_slv_demux_pkg::*;

  localparam int N_TGT = 2;

  logic                           clk = 1'b0;
  logic                           rstn;
  logic                           cache_if_req_valid;
  cpu_cache_if_req_t              cache_if_req;
  logic                           cache_if_req_ready;
  logic                           cache_if_resp_valid;
  cpu_cache_if_resp_t             cache_if_resp;
  logic                           cache_if_resp_ready;
  logic [N_TGT-1:0]               tgt_req_valid;
  cpu_cache_if_req_t [N_TGT-1:0]  tgt_req;
  logic [N_TGT-1:0]               tgt_req_ready;
  logic [N_TGT-1:0]               tgt_resp_valid;
  cpu_cache_if_resp_t [N_TGT-1:0] tgt_resp;
  logic [N_TGT-1:0]               tgt_resp_ready;

  orv64_cache_noc_slv_demux #(
    .N_TGT(N_TGT), .TGT_SEL_LSB(6), .MAX_OUTSTANDING(4)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .cache_if_req_valid  (cache_if_req_valid),
    .cache_if_req        (cache_if_req),
    .cache_if_req_ready  (cache_if_req_ready),
    .cache_if_resp_valid (cache_if_resp_valid),
    .cache_if_resp       (cache_if_resp),
    .cache_if_resp_ready (cache_if_resp_ready),
    .tgt_req_valid       (tgt_req_valid),
    .tgt_req             (tgt_req),
    .tgt_req_ready       (tgt_req_ready),
    .tgt_resp_valid      (tgt_resp_valid),
    .tgt_resp            (tgt_resp),
    .tgt_resp_ready      (tgt_resp_ready)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [7:0] tid);
    return {32'hD00D_0000, 24'h0, tid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and hold it until accepted (bounded).
  task automatic send_req(input logic [39:0] paddr, input logic [7:0] tid);
    int cyc;
    cache_if_req           = '0;
    cache_if_req.req_paddr = paddr;
    cache_if_req.req_tid   = tid;
    cache_if_req_valid     = 1'b1;
    #1;
    cyc = 0;
    while (!cache_if_req_ready && cyc < 20) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (!cache_if_req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: tid 0x%0h never accepted", tid);
    end
    @(posedge clk);
    #1;
    cache_if_req_valid = 1'b0;
  endtask

  // Present responses on the targets in mask for exactly one cycle.
  task automatic send_resp(input logic [1:0] mask, input logic [7:0] tid0, input logic [7:0] tid1);
    tgt_resp[0].resp_tid  = tid0;
    tgt_resp[0].resp_type = 2'd0;
    tgt_resp[0].resp_data = data_of(tid0);
    tgt_resp[1].resp_tid  = tid1;
    tgt_resp[1].resp_type = 2'd0;
    tgt_resp[1].resp_data = data_of(tid1);
    tgt_resp_valid        = mask;
    #1;
    check("tgt_resp_ready_at_send", 64'(tgt_resp_ready & mask), 64'(mask));
    @(posedge clk);
    #1;
    tgt_resp_valid = '0;
  endtask

  // Monitor: every upstream response handshake must match the queue head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rstn && cache_if_resp_valid && cache_if_resp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL resp_unexpected: tid 0x%0h with empty scoreboard", cache_if_resp.resp_tid);
        end else begin
          e = exp_q.pop_front();
          check("resp_tid", 64'(cache_if_resp.resp_tid), 64'(e));
          check("resp_data", cache_if_resp.resp_data, data_of(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn                = 1'b0;
    cache_if_req_valid  = 1'b0;
    cache_if_req        = '0;
    cache_if_resp_ready = 1'b1;
    tgt_req_ready       = '1;
    tgt_resp_valid      = '0;
    tgt_resp            = '0;
    #1;
    check("rst_resp_valid", 64'(cache_if_resp_valid), 64'd0);
    check("rst_tgt_resp_ready", 64'(tgt_resp_ready), 64'h3);
    check("rst_tgt_req_valid", 64'(tgt_req_valid), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();

    // Single request to paddr 0x40 decodes to target 1 combinationally.
    cache_if_req           = '0;
    cache_if_req.req_paddr = 40'h40;
    cache_if_req.req_tid   = 8'h05;
    cache_if_req_valid     = 1'b1;
    #1;
    check("s1_tgt_req_valid", 64'(tgt_req_valid), 64'h2);
    check("s1_req_ready", 64'(cache_if_req_ready), 64'd1);
    check("s1_tgt_req_tid", 64'(tgt_req[1].req_tid), 64'h05);
    @(posedge clk);
    #1;
    cache_if_req_valid = 1'b0;
    check("s1_oc1_after_req", 64'(dut.oc[1]), 64'd1);
    exp_q.push_back(8'h05);
    send_resp(2'b10, 8'h00, 8'h05);
    check("s1_resp_valid_next_cycle", 64'(cache_if_resp_valid), 64'd1);
    check("s1_oc1_after_resp", 64'(dut.oc[1]), 64'd0);
    tick();

    // Outstanding limit: four accepted, fifth stalls until a response returns.
    for (int i = 1; i <= 4; i++) send_req(40'h0, 8'(i));
    check("s2_oc0_full", 64'(dut.oc[0]), 64'd4);
    cache_if_req           = '0;
    cache_if_req.req_tid   = 8'h05;
    cache_if_req_valid     = 1'b1;
    #1;
    check("s2_fifth_ready", 64'(cache_if_req_ready), 64'd0);
    check("s2_fifth_valid", 64'(tgt_req_valid), 64'd0);
    tick();
    check("s2_fifth_ready_later", 64'(cache_if_req_ready), 64'd0);
    exp_q.push_back(8'h01);
    send_resp(2'b01, 8'h01, 8'h00);
    #1;
    check("s2_fifth_ready_after_resp", 64'(cache_if_req_ready), 64'd1);
    @(posedge clk);
    #1;
    cache_if_req_valid = 1'b0;
    check("s2_oc0_refill", 64'(dut.oc[0]), 64'd4);
    for (int i = 2; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      send_resp(2'b01, 8'(i), 8'h00);
    end
    tick();
    check("s2_oc0_drained", 64'(dut.oc[0]), 64'd0);

`ifndef ORV64_CACHE_NOC_ORDER_EN
    // Round-robin: pointer is at 1 here; a lone t1 response moves it to 0.
    send_req(40'h00, 8'h10);
    send_req(40'h00, 8'h11);
    send_req(40'h00, 8'h12);
    send_req(40'h40, 8'h20);
    send_req(40'h40, 8'h21);
    send_req(40'h40, 8'h22);
    exp_q.push_back(8'h20);
    send_resp(2'b10, 8'h00, 8'h20);
    tick(); tick();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h21);
    send_resp(2'b11, 8'h10, 8'h21);
    check("s3_pair1_first", 64'(cache_if_resp.resp_tid), 64'h10);
    tick(); tick();
    exp_q.push_back(8'h11);
    send_resp(2'b01, 8'h11, 8'h00);
    tick(); tick();
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h12);
    send_resp(2'b11, 8'h12, 8'h22);
    check("s3_pair2_first", 64'(cache_if_resp.resp_tid), 64'h22);
    tick(); tick();
`endif

    // Cross-target ordering: t0 outstanding, then a request to t1.
    send_req(40'h00, 8'h30);
    cache_if_req           = '0;
    cache_if_req.req_paddr = 40'h40;
    cache_if_req.req_tid   = 8'h31;
    cache_if_req_valid     = 1'b1;
    #1;
`ifdef ORV64_CACHE_NOC_ORDER_EN
    check("s4_order_blocked_ready", 64'(cache_if_req_ready), 64'd0);
    check("s4_order_blocked_valid", 64'(tgt_req_valid), 64'd0);
    exp_q.push_back(8'h30);
    send_resp(2'b01, 8'h30, 8'h00);
    #1;
    check("s4_order_released", 64'(cache_if_req_ready), 64'd1);
    @(posedge clk);
    #1;
    cache_if_req_valid = 1'b0;
    exp_q.push_back(8'h31);
    send_resp(2'b10, 8'h00, 8'h31);
`else
    check("s4_unordered_ready", 64'(cache_if_req_ready), 64'd1);
    check("s4_unordered_valid", 64'(tgt_req_valid), 64'h2);
    @(posedge clk);
    #1;
    cache_if_req_valid = 1'b0;
    exp_q.push_back(8'h30);
    send_resp(2'b01, 8'h30, 8'h00);
    exp_q.push_back(8'h31);
    send_resp(2'b10, 8'h00, 8'h31);
`endif
    tick(); tick();

`ifndef ORV64_CACHE_NOC_ORDER_EN
    // Backpressure with both skids full: pointer is 0, so t0 is presented.
    send_req(40'h00, 8'h50);
    send_req(40'h40, 8'h51);
    cache_if_resp_ready = 1'b0;
    send_resp(2'b11, 8'h50, 8'h51);
    for (int i = 0; i < 3; i++) begin
      check("s5_hold_valid", 64'(cache_if_resp_valid), 64'd1);
      check("s5_hold_tid", 64'(cache_if_resp.resp_tid), 64'h50);
      check("s5_hold_data", cache_if_resp.resp_data, data_of(8'h50));
      check("s5_hold_tgt_ready", 64'(tgt_resp_ready), 64'd0);
      tick();
    end
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h51);
    cache_if_resp_ready = 1'b1;
    tick(); tick(); tick();
`endif

    // Asynchronous reset with outstanding requests and a buffered response.
    send_req(40'h00, 8'h60);
    send_req(40'h00, 8'h61);
    send_req(40'h00, 8'h62);
    cache_if_resp_ready = 1'b0;
    send_resp(2'b01, 8'h60, 8'h00);
    #2;
    rstn = 1'b0;
    #1;
    check("s6_rst_resp_valid", 64'(cache_if_resp_valid), 64'd0);
    check("s6_rst_tgt_resp_ready", 64'(tgt_resp_ready), 64'h3);
    check("s6_rst_tgt_req_valid", 64'(tgt_req_valid), 64'd0);
    check("s6_rst_oc0", 64'(dut.oc[0]), 64'd0);
    cache_if_resp_ready = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    send_req(40'h00, 8'h70);
    check("s6_post_rst_oc0", 64'(dut.oc[0]), 64'd1);
    exp_q.push_back(8'h70);
    send_resp(2'b01, 8'h70, 8'h00);
    tick(); tick(); tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
